// File: rtl/counter_pkg.sv
// Shared definitions for the counter link: checker state encoding, the default
// count width used by the counter block, and an elaboration-time log2 helper.
package counter_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 2;

    // Ceiling log2, never below 1 so a value of 1 still yields a usable bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c);
        return (c == {W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Receive-side sequence checker for a modulo-2^WIDTH up-counter stream: locks
// onto the increment sequence, pulses on breaks, and tallies errors and wraps.
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  val,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  expected
);

    localparam int RUN_W = clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_TARGET = RUN_W'(LOCK_COUNT);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             match;
    logic             err_inc;
    logic             wrap_inc;

    assign match    = (val == expected);
    assign run_next = run + 1'b1;
    assign err_inc  = in_valid && (state == LOCKED) && !match;
    assign wrap_inc = in_valid && (state == LOCKED) && match && (val == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            run       <= '0;
            expected  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                // Always resynchronise to the sample just seen, matched or not.
                expected <= val + 1'b1;
                case (state)
                    HUNT: begin
                        run    <= '0;
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (!match) begin
                            run <= '0;
                        end else if (run_next == LOCK_TARGET) begin
                            run    <= '0;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            run <= run_next;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            err_pulse <= 1'b1;
                            run       <= '0;
                            state     <= ACQUIRE;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        run    <= '0;
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clear (clear),
        .count (err_count)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap_inc),
        .clear (clear),
        .count (wrap_count)
    );

endmodule
